pcileech_com_rxgear: RTL and testbench

//  Parametrised RX gearbox for the COM core. Packs IN_W-bit words from any COM
//  PHY (FT601, RMII ETH, future 8/16-bit links) into 64-bit command words.

---
 rtl/pcileech_com_rxgear_if.sv | 23 ++
 rtl/pcileech_com_rxgear.sv | 148 ++++++++++++++
 tb/tb_pcileech_com_rxgear.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_com_rxgear_if.sv
// RX gearbox bus: PHY-side word stream in, packed 64-bit command stream out.
// master = PHY/consumer side, slave = gearbox.
interface pcileech_com_rxgear_if #(
    parameter int IN_W = 32
);
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [63:0]     out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_is_init;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_is_init
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_is_init
    );
endinterface

// File: rtl/pcileech_com_rxgear.sv
// COM RX gearbox: injects on-board init commands after reset, then packs
// IN_W-bit PHY words into 64-bit commands with an idle timeout on partial words.
module pcileech_com_rxgear #(
    parameter int IN_W        = 32,
    parameter int NUM_INIT    = 5,
    parameter logic [64*((NUM_INIT > 0) ? NUM_INIT : 1)-1:0] INIT_DATA = '0,
    parameter int INIT_DELAY  = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pcileech_com_rxgear_if.slave  bus,
    output logic                  init_done,
    output logic [CNT_W-1:0]      stat_drop_cnt,
    output logic [CNT_W-1:0]      stat_word_cnt
);
    localparam int RATIO  = 64 / IN_W;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int IDX_W  = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
    localparam int DLY_W  = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [63:0] init_word(input logic [IDX_W-1:0] k);
        return INIT_DATA[64*k +: 64];
    endfunction

    logic [1:0]        state;
    logic [DLY_W-1:0]  dly;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] lane;
    logic [IDLE_W-1:0] idle;
    logic [63:0]       out_data_p1;
    logic              vld_p1;
    logic              is_init_p1;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  word_cnt;

    logic              in_ready_w;
    logic              accept;
    logic              last_lane;
    logic              timeout_hit;
    logic [63:0]       packed_w;

    assign in_ready_w  = (state == S_RUN) & (~vld_p1 | bus.out_ready);
    assign accept      = bus.in_valid & in_ready_w;
    assign last_lane   = (lane == LANE_W'(RATIO - 1));
    assign timeout_hit = (TIMEOUT_CYC > 0) && (state == S_RUN) && (lane != '0) &&
                         !accept && (idle == IDLE_W'(TIMEOUT_CYC - 1));

    // Stage p0: shift register holding the partial word, oldest word on top
    generate
        if (RATIO > 1) begin : g_pack
            logic [63-IN_W:0] shreg_p0;
            always_ff @(posedge clk) begin
                if (accept) shreg_p0 <= packed_w[63-IN_W:0];
            end
            assign packed_w = {shreg_p0, bus.in_data};
        end else begin : g_pass
            assign packed_w = bus.in_data;
        end
    endgenerate

    // Stage p1: output register shared by injected and packed words
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT;
            dly         <= '0;
            idx         <= '0;
            lane        <= '0;
            idle        <= '0;
            out_data_p1 <= '0;
            vld_p1      <= 1'b0;
            is_init_p1  <= 1'b0;
            drop_cnt    <= '0;
            word_cnt    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    dly <= dly + 1'b1;
                    if (dly == DLY_W'(INIT_DELAY - 1)) begin
                        if (NUM_INIT == 0) begin
                            state <= S_RUN;
                        end else begin
                            state       <= S_INIT;
                            idx         <= '0;
                            out_data_p1 <= init_word('0);
                            vld_p1      <= 1'b1;
                            is_init_p1  <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    if (vld_p1 & bus.out_ready) begin
                        if (idx == IDX_W'(NUM_INIT - 1)) begin
                            state      <= S_RUN;
                            vld_p1     <= 1'b0;
                            is_init_p1 <= 1'b0;
                        end else begin
                            idx         <= idx + 1'b1;
                            out_data_p1 <= init_word(idx + 1'b1);
                        end
                    end
                end
                S_RUN: begin
                    if (vld_p1 & bus.out_ready) vld_p1 <= 1'b0;
                    // an accept always beats a coincident timeout
                    if (accept) begin
                        idle <= '0;
                        if (last_lane) begin
                            out_data_p1 <= packed_w;
                            vld_p1      <= 1'b1;
                            lane        <= '0;
                            word_cnt    <= sat_inc(word_cnt);
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        lane     <= '0;
                        idle     <= '0;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if ((lane == '0) || (TIMEOUT_CYC == 0)) begin
                        idle <= '0;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_data    = out_data_p1;
    assign bus.out_valid   = vld_p1;
    assign bus.out_is_init = is_init_p1;
    assign init_done       = (state == S_RUN);
    assign stat_drop_cnt   = drop_cnt;
    assign stat_word_cnt   = word_cnt;
endmodule

// File: tb/tb_pcileech_com_rxgear.sv
// Directed bench for the COM RX gearbox: injection, 32/8/64-bit packing,
// idle timeout, back-pressure, counter saturation and reset mid-operation.
module tb_pcileech_com_rxgear;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    pcileech_com_rxgear_if #(.IN_W(32)) b32 ();
    pcileech_com_rxgear_if #(.IN_W(8))  b8 ();
    pcileech_com_rxgear_if #(.IN_W(64)) b64 ();

    logic        done32, done8, done64;
    logic [15:0] drop32, word32, drop64, word64;
    logic [1:0]  drop8, word8;

    pcileech_com_rxgear #(
        .IN_W(32), .NUM_INIT(2), .INIT_DATA({64'hB, 64'hA}),
        .INIT_DELAY(16), .TIMEOUT_CYC(4), .CNT_W(16)
    ) dut32 (
        .clk(clk), .rst(rst), .bus(b32), .init_done(done32),
        .stat_drop_cnt(drop32), .stat_word_cnt(word32)
    );

    pcileech_com_rxgear #(
        .IN_W(8), .NUM_INIT(0), .INIT_DELAY(16), .TIMEOUT_CYC(255), .CNT_W(2)
    ) dut8 (
        .clk(clk), .rst(rst), .bus(b8), .init_done(done8),
        .stat_drop_cnt(drop8), .stat_word_cnt(word8)
    );

    pcileech_com_rxgear #(
        .IN_W(64), .NUM_INIT(0), .INIT_DELAY(1), .TIMEOUT_CYC(0), .CNT_W(16)
    ) dut64 (
        .clk(clk), .rst(rst), .bus(b64), .init_done(done64),
        .stat_drop_cnt(drop64), .stat_word_cnt(word64)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        orr;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_od;
        logic [15:0] e_drop;
        logic [15:0] e_word;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic iv, logic [31:0] d, logic orr, logic ir, logic ov,
                                logic [63:0] od, logic [15:0] dr, logic [15:0] wd);
        vec_t v;
        v.iv = iv; v.d = d; v.orr = orr; v.e_ir = ir; v.e_ov = ov;
        v.e_od = od; v.e_drop = dr; v.e_word = wd;
        return v;
    endfunction

    function automatic logic [63:0] bytes_word(int w);
        logic [63:0] r = '0;
        for (int k = 0; k < 8; k++) r = {r[55:0], 8'(w * 8 + k + 1)};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        @(negedge clk);
        chk("rst_ir32",   b32.in_ready, 0);
        chk("rst_ov32",   b32.out_valid, 0);
        chk("rst_od32",   b32.out_data, 0);
        chk("rst_init32", b32.out_is_init, 0);
        chk("rst_done32", done32, 0);
        chk("rst_drop32", drop32, 0);
        chk("rst_word32", word32, 0);
        chk("rst_ir8",    b8.in_ready, 0);
        chk("rst_word8",  word8, 0);
        chk("rst_done64", done64, 0);
    endtask

    // release reset and follow all three instances through their start-up delay
    task automatic release_and_wait();
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("wait_ov32", b32.out_valid, (c == 15));
            if (c == 0)  chk("delay1_done64", done64, 1);
            if (c == 14) chk("wait_done8", done8, 0);
            if (c == 15) chk("wait_done8", done8, 1);
        end
        chk("init_word0", b32.out_data, 64'hA);
        chk("init_flag0", b32.out_is_init, 1);
        chk("init_ir0",   b32.in_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        b32.in_valid = 0; b32.in_data = '0; b32.out_ready = 0;
        b8.in_valid  = 0; b8.in_data  = '0; b8.out_ready  = 0;
        b64.in_valid = 0; b64.in_data = '0; b64.out_ready = 0;

        tbl[0]  = mk(1, 32'h11111111, 1, 1, 0, 64'h0, 0, 0);
        tbl[1]  = mk(1, 32'h22222222, 1, 1, 0, 64'h0, 0, 0);
        tbl[2]  = mk(0, 32'h0,        1, 1, 1, 64'h11111111_22222222, 0, 1);
        tbl[3]  = mk(1, 32'h33333333, 1, 1, 0, 64'h0, 0, 1);
        tbl[4]  = mk(0, 32'h0,        1, 1, 0, 64'h0, 0, 1);
        tbl[5]  = mk(0, 32'h0,        1, 1, 0, 64'h0, 0, 1);
        tbl[6]  = mk(0, 32'h0,        1, 1, 0, 64'h0, 0, 1);
        tbl[7]  = mk(0, 32'h0,        1, 1, 0, 64'h0, 0, 1);
        tbl[8]  = mk(1, 32'hAA,       1, 1, 0, 64'h0, 1, 1);
        tbl[9]  = mk(1, 32'hBB,       1, 1, 0, 64'h0, 1, 1);
        tbl[10] = mk(0, 32'h0,        1, 1, 1, 64'h000000AA_000000BB, 1, 2);
        tbl[11] = mk(1, 32'h1,        1, 1, 0, 64'h0, 1, 2);
        tbl[12] = mk(0, 32'h0,        1, 1, 0, 64'h0, 1, 2);
        tbl[13] = mk(0, 32'h0,        1, 1, 0, 64'h0, 1, 2);
        tbl[14] = mk(0, 32'h0,        1, 1, 0, 64'h0, 1, 2);
        tbl[15] = mk(1, 32'h2,        1, 1, 0, 64'h0, 1, 2);
        tbl[16] = mk(0, 32'h0,        0, 0, 1, 64'h00000001_00000002, 1, 3);
        tbl[17] = mk(1, 32'h5,        0, 0, 1, 64'h00000001_00000002, 1, 3);
        tbl[18] = mk(1, 32'h5,        1, 1, 1, 64'h00000001_00000002, 1, 3);
        tbl[19] = mk(1, 32'h6,        1, 1, 0, 64'h0, 1, 3);
        tbl[20] = mk(0, 32'h0,        1, 1, 1, 64'h00000005_00000006, 1, 4);
        tbl[21] = mk(0, 32'h0,        1, 1, 0, 64'h0, 1, 4);

        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        tick();

        // injection: word A held under back-pressure, then A and B handed over
        release_and_wait();
        tick();
        chk("init_hold_ov", b32.out_valid, 1);
        chk("init_hold_od", b32.out_data, 64'hA);
        b32.out_ready = 1; b32.in_valid = 1; b32.in_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("init_bp_ir", b32.in_ready, 0);
        tick();
        b32.in_valid = 0;
        chk("init_word1", b32.out_data, 64'hB);
        chk("init_flag1", b32.out_is_init, 1);
        chk("init_ir1",   b32.in_ready, 0);
        chk("init_done_pre", done32, 0);
        tick();
        chk("run_ov",   b32.out_valid, 0);
        chk("run_flag", b32.out_is_init, 0);
        chk("run_done", done32, 1);
        chk("run_ir",   b32.in_ready, 1);

        // 32-bit packing, timeout drop, accept-beats-timeout, output stall
        for (int i = 0; i < 22; i++) begin
            b32.in_valid = tbl[i].iv; b32.in_data = tbl[i].d; b32.out_ready = tbl[i].orr;
            @(negedge clk);
            chk($sformatf("v%0d_ir", i), b32.in_ready, tbl[i].e_ir);
            chk($sformatf("v%0d_ov", i), b32.out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("v%0d_od", i), b32.out_data, tbl[i].e_od);
            chk($sformatf("v%0d_drop", i), drop32, tbl[i].e_drop);
            chk($sformatf("v%0d_word", i), word32, tbl[i].e_word);
            tick();
        end
        b32.in_valid = 0;

        // 8-bit lane: four back-to-back words, word counter saturates at 3
        b8.out_ready = 1;
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 8; i++) begin
                b8.in_valid = 1; b8.in_data = 8'(w * 8 + i + 1);
                @(negedge clk);
                chk("b8_ir", b8.in_ready, 1);
                if (w > 0 && i == 0) begin
                    chk("b8_ov", b8.out_valid, 1);
                    chk("b8_od", b8.out_data, bytes_word(w - 1));
                    chk("b8_word", word8, (w > 3) ? 3 : w);
                end
                tick();
            end
        end
        b8.in_valid = 0;
        @(negedge clk);
        chk("b8_last_ov", b8.out_valid, 1);
        chk("b8_last_od", b8.out_data, bytes_word(3));
        chk("b8_sat", word8, 3);
        tick();

        // 64-bit pass-through: stall, then release together with a new accept
        b64.out_ready = 0; b64.in_valid = 1; b64.in_data = 64'h01234567_89ABCDEF;
        @(negedge clk);
        chk("p64_ir0", b64.in_ready, 1);
        chk("p64_ov0", b64.out_valid, 0);
        tick();
        b64.in_data = 64'hFEDCBA98_76543210;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("p64_stall_ir", b64.in_ready, 0);
            chk("p64_stall_ov", b64.out_valid, 1);
            chk("p64_stall_od", b64.out_data, 64'h01234567_89ABCDEF);
            tick();
        end
        b64.out_ready = 1;
        @(negedge clk);
        chk("p64_rel_ir", b64.in_ready, 1);
        tick();
        b64.in_valid = 0; b64.out_ready = 0;
        @(negedge clk);
        chk("p64_next_ov", b64.out_valid, 1);
        chk("p64_next_od", b64.out_data, 64'hFEDCBA98_76543210);
        chk("p64_word", word64, 2);
        chk("p64_flag", b64.out_is_init, 0);
        tick();

        // reset with partial words pending in the 32- and 8-bit instances
        b32.out_ready = 1; b32.in_valid = 1; b32.in_data = 32'h77777777;
        b8.in_valid = 1; b8.in_data = 8'hEE;
        tick();
        b32.in_valid = 0;
        tick();
        tick();
        b8.in_valid = 0;
        rst = 1'b1;
        tick();
        chk_reset();
        tick();
        release_and_wait();
        tick();
        chk("rst2_word1", b32.out_data, 64'hB);

        // reset in the middle of injection: must restart from word 0
        rst = 1'b1;
        tick();
        chk_reset();
        tick();
        release_and_wait();
        tick();
        chk("rst3_word1", b32.out_data, 64'hB);
        tick();
        chk("rst3_done", done32, 1);

        b32.in_valid = 1; b32.in_data = 32'h12345678;
        tick();
        b32.in_data = 32'h9ABCDEF0;
        tick();
        b32.in_valid = 0;
        @(negedge clk);
        chk("post_rst_od32", b32.out_data, 64'h12345678_9ABCDEF0);
        chk("post_rst_ov32", b32.out_valid, 1);
        chk("post_rst_word32", word32, 1);
        chk("post_rst_drop32", drop32, 0);
        tick();

        for (int i = 0; i < 8; i++) begin
            b8.in_valid = 1; b8.in_data = 8'hA1 + 8'(i);
            tick();
        end
        b8.in_valid = 0;
        @(negedge clk);
        chk("post_rst_od8", b8.out_data, 64'hA1A2A3A4_A5A6A7A8);
        chk("post_rst_word8", word8, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
